// File: rtl/ring_store_pkg.sv
// Shared sizing and bit helpers for the ring store: word width, slot count,
// even parity and slot extraction from the generator address.
package ring_pkg;

    function automatic int word_bits(input int counter_size);
        return 1 << (counter_size + 1);
    endfunction

    function automatic int ring_depth(input int counter_size);
        return 1 << counter_size;
    endfunction

    function automatic logic even_parity(input logic [63:0] v);
        return ^v;
    endfunction

    // Slot is the address field above the bit-within-word counter.
    function automatic int slot_index(input logic [63:0] adrs, input int counter_size);
        return int'((adrs >> (counter_size + 1)) & ((64'd1 << counter_size) - 64'd1));
    endfunction

endpackage

// File: rtl/ring_store_if.sv
// Generator/transmitter-facing signals of ring_store; master drives the
// address, strobes and serial input, slave is the store itself.
interface ring_store_if #(parameter int COUNTER_SIZE = 2);

    logic [2*COUNTER_SIZE:0] ramadrs;
    logic                    oeenable;
    logic                    outstrobe;
    logic                    indata;
    logic                    outdata;
    logic                    out_valid;
    logic                    frame_mark;
    logic                    parity_err;

    modport master (
        output ramadrs, oeenable, outstrobe, indata,
        input  outdata, out_valid, frame_mark, parity_err
    );

    modport slave (
        input  ramadrs, oeenable, outstrobe, indata,
        output outdata, out_valid, frame_mark, parity_err
    );

endinterface

// File: rtl/ring_store_mem.sv
// DEPTH x DW word store, combinational read of the addressed slot and
// write on the same edge, so a commit sees the old word; never reset.
module ring_store_mem #(
    parameter int DEPTH = 4,
    parameter int DW    = 8,
    parameter int AW    = 2
) (
    input  logic          clock,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wr_dat,
    output logic [DW-1:0] rd_dat
);

    logic [DW-1:0] mem [DEPTH];

    assign rd_dat = mem[addr];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[addr] <= wr_dat;
        end
    end

endmodule

// File: rtl/ring_store.sv
// Serial ring delay: output is the input stream delayed (DEPTH+1)*W clocks, no backpressure.
// Define RING_STORE_PARITY_EN to store a parity bit per word and pulse parity_err on read-back mismatch.
module ring_store
    import ring_pkg::*;
#(
    parameter int COUNTER_SIZE = 2
) (
    input  logic        clock,
    input  logic        reset,
    ring_store_if.slave bus
);

    localparam int W     = word_bits(COUNTER_SIZE);
    localparam int DEPTH = ring_depth(COUNTER_SIZE);
    localparam int AW    = COUNTER_SIZE;
    localparam int CW    = $clog2(DEPTH + 2);
`ifdef RING_STORE_PARITY_EN
    localparam int DW    = W + 1;
`else
    localparam int DW    = W;
`endif

    localparam logic [CW-1:0] CNT_MAX   = CW'(DEPTH + 1);
    localparam logic [CW-1:0] CNT_PRIME = CW'(DEPTH);

    logic [W-1:0]  sreg;
    logic [W-1:0]  oreg;
    logic [CW-1:0] commit_cnt;
    logic [CW-1:0] cnt_nxt;
    logic          out_valid_q;
    logic          frame_mark_q;
    logic [AW-1:0] slot;
    logic [DW-1:0] wr_dat;
    logic [DW-1:0] rd_dat;

    assign slot = AW'(slot_index(64'(bus.ramadrs), COUNTER_SIZE));

`ifdef RING_STORE_PARITY_EN
    assign wr_dat = {even_parity(64'(sreg)), sreg};
`else
    assign wr_dat = sreg;
`endif

    ring_store_mem #(
        .DEPTH (DEPTH),
        .DW    (DW),
        .AW    (AW)
    ) u_mem (
        .clock  (clock),
        .we     (bus.oeenable),
        .addr   (slot),
        .wr_dat (wr_dat),
        .rd_dat (rd_dat)
    );

    always_comb begin
        cnt_nxt = commit_cnt;
        if (bus.oeenable && (commit_cnt != CNT_MAX)) begin
            cnt_nxt = commit_cnt + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sreg         <= '0;
            oreg         <= '0;
            commit_cnt   <= '0;
            out_valid_q  <= 1'b0;
            frame_mark_q <= 1'b0;
        end else begin
            sreg         <= {sreg[W-2:0], bus.indata};
            commit_cnt   <= cnt_nxt;
            out_valid_q  <= (cnt_nxt == CNT_MAX);
            frame_mark_q <= bus.outstrobe & out_valid_q;
            if (bus.oeenable) begin
                oreg <= rd_dat[W-1:0];
            end else begin
                oreg <= {oreg[W-2:0], 1'b0};
            end
        end
    end

`ifdef RING_STORE_PARITY_EN
    logic parity_err_q;

    // Slots are only trusted once every slot has been written since reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            parity_err_q <= 1'b0;
        end else begin
            parity_err_q <= bus.oeenable && (commit_cnt >= CNT_PRIME) &&
                            (even_parity(64'(rd_dat[W-1:0])) != rd_dat[W]);
        end
    end

    assign bus.parity_err = parity_err_q;
`else
    assign bus.parity_err = 1'b0;
`endif

    assign bus.outdata    = oreg[W-1] & out_valid_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.frame_mark = frame_mark_q;

endmodule

// File: doc/ring_store.md
# ring_store

Serial ring-buffer data store driven by the address/strobe generator. Assembles the serial input bit stream into words and writes each word into a small memory at the slot selected by the upper address bits. It reads back the word written one full ring pass earlier and re-serialises it. The result is the input stream delayed by exactly (DEPTH+1) words, with frame markers for the downstream transmitter.

## Interface
- COUNTER_SIZE, default 2: must match the address generator's counter size. Must be ≥1.
- Derived values:
  - W = 2^(COUNTER_SIZE+1): bits per word.
  - DEPTH = 2^COUNTER_SIZE: number of memory slots.
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high.
- ramadrs  in  2*COUNTER_SIZE+1  free-running address from the generator.
- oeenable  in  1  one-cycle word-commit strobe, once every W clocks.
- outstrobe  in  1  end-of-ring strobe from the generator.
- indata  in  1  serial input bit, sampled every clock.
- outdata  out  1  serial delayed output, MSB of each word first.
- out_valid  out  1  high once delayed data is genuine.
- frame_mark  out  1  registered `outstrobe & out_valid`.
- parity_err  out  1  one-cycle pulse on a read-back parity mismatch; constant 0 without the macro.

## Operation
- **Input shift register `sreg` (W bits):** `sreg <= {sreg[W-2:0], indata}` on every clock edge, unconditionally.
- **Commit edge** (edge with oeenable=1):
  - slot = ramadrs[2*COUNTER_SIZE:COUNTER_SIZE+1], sampled at that edge.
  - Memory is read-before-write. The old mem[slot] loads into output register `oreg`. The pre-edge `sreg` value is written to mem[slot].
- **Non-commit edge:** `oreg <= {oreg[W-2:0], 1'b0}`.
- **`commit_cnt`:**
  - Counts commit edges and saturates at DEPTH+1.
  - out_valid = (commit_cnt == DEPTH+1), registered.
- **Outputs:**
  - outdata = oreg[W-1] & out_valid.
  - Before out_valid, outdata is 0 and stale memory contents are never visible.
- **Slot order:** set solely by ramadrs. Wrap from slot DEPTH-1 to slot 0 is seamless; no bubble.
- **oeenable spacing:** oeenable arriving at a spacing other than W clocks is out of contract. The block still commits on every oeenable, and the bench flags the spacing violation.
- **Reset:**
  - Asynchronous reset at any time, including mid-word, clears sreg, oreg, commit_cnt, out_valid, frame_mark and parity_err to 0.
  - Memory contents are not cleared.
  - The address generator must be reset in the same cycle.

## Timing
- **Reset values:** outdata=0, out_valid=0, frame_mark=0, parity_err=0.
- **Latency:** a bit sampled at edge t appears on outdata after edge t+(DEPTH+1)*W. For COUNTER_SIZE=2 that is 40 clocks.
- **out_valid:** rises after the (DEPTH+1)th commit edge following reset. It stays high until the next reset.
- **frame_mark:** one-cycle-registered copy of outstrobe, gated by out_valid.
- **parity_err:** asserts for exactly one cycle after the faulty commit edge.

## Configuration
- **RING_STORE_PARITY_EN defined:**
  - Memory is W+1 bits wide. Stored bit = even parity (XOR) of sreg at commit.
  - On each commit, the read word's recomputed parity is compared with its stored bit.
  - A mismatch while commit_cnt ≥ DEPTH pulses parity_err.
- **Undefined:**
  - Memory is W bits wide.
  - parity_err is tied 0; the port remains present.

## Structure
- Shared package `ring_pkg`:
  - Functions for W and DEPTH from COUNTER_SIZE.
  - Even-parity function.
  - Slot-index extraction.
- One sub-module `ring_store_mem`:
  - DEPTH × (W or W+1) synchronous RAM with read-before-write.
  - Single write enable tied to oeenable.
  - Memory is never reset.
- Top level holds sreg, oreg, commit_cnt and output registers.

## Test plan
- **Reset check:** reset high mid-stream -> all outputs 0 within the same cycle; commit_cnt restarts, so out_valid returns only after 5 new commits (COUNTER_SIZE=2).
- **Delay:** walking-one stream, single 1 at edge 3 after reset release (generator reset together) -> outdata=1 exactly 40 edges later, 0 elsewhere. out_valid rises after the 5th commit.
- **Random stream:** 1000 random bits -> outdata equals indata delayed 40 clocks once out_valid=1; zero mismatches.
- **Wrap-around:** run for 3 full ring passes with word pattern 0xA5, 0x3C, 0xFF, 0x00 per slot -> identical word sequence on output across the slot-3→0 wrap; frame_mark pulses once per ring pass.
- **Parity (macro defined):** flip bit 0 of mem[2] by hierarchical deposit after priming -> parity_err pulses once, one cycle after slot 2's commit edge. Macro undefined -> parity_err stays 0.
